// File: rtl/rob_commit_ctrl_if.sv
// rob_commit_ctrl_if: decoder, CDB, operand-query and commit/flush signals of the reorder buffer.
interface rob_commit_ctrl_if #(
    parameter int ROB_IDX = 4,
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5
);
    logic               in_decoder_alloc_enable;
    logic [REG_W-1:0]   in_decoder_rd;
    logic               in_decoder_is_branch;
    logic               out_decoder_full;
    logic [ROB_IDX-1:0] out_decoder_alloc_tag;
    logic               in_cdb_enable;
    logic [ROB_IDX-1:0] in_cdb_tag;
    logic [DATA_W-1:0]  in_cdb_value;
    logic               in_cdb_mispredict;
    logic [DATA_W-1:0]  in_cdb_target_pc;
    logic [ROB_IDX-1:0] in_query_tag_a;
    logic [ROB_IDX-1:0] in_query_tag_b;
    logic               out_query_ready_a;
    logic               out_query_ready_b;
    logic [DATA_W-1:0]  out_query_value_a;
    logic [DATA_W-1:0]  out_query_value_b;
    logic               out_reg_commit_enable;
    logic [REG_W-1:0]   out_reg_rd_addr;
    logic [DATA_W-1:0]  out_reg_rd_value;
    logic [ROB_IDX-1:0] out_reg_reorder;
    logic               out_flush_enable;
    logic [DATA_W-1:0]  out_flush_pc;

    modport master (
        output in_decoder_alloc_enable, in_decoder_rd, in_decoder_is_branch,
        output in_cdb_enable, in_cdb_tag, in_cdb_value, in_cdb_mispredict, in_cdb_target_pc,
        output in_query_tag_a, in_query_tag_b,
        input  out_decoder_full, out_decoder_alloc_tag,
        input  out_query_ready_a, out_query_ready_b, out_query_value_a, out_query_value_b,
        input  out_reg_commit_enable, out_reg_rd_addr, out_reg_rd_value, out_reg_reorder,
        input  out_flush_enable, out_flush_pc
    );

    modport slave (
        input  in_decoder_alloc_enable, in_decoder_rd, in_decoder_is_branch,
        input  in_cdb_enable, in_cdb_tag, in_cdb_value, in_cdb_mispredict, in_cdb_target_pc,
        input  in_query_tag_a, in_query_tag_b,
        output out_decoder_full, out_decoder_alloc_tag,
        output out_query_ready_a, out_query_ready_b, out_query_value_a, out_query_value_b,
        output out_reg_commit_enable, out_reg_rd_addr, out_reg_rd_value, out_reg_reorder,
        output out_flush_enable, out_flush_pc
    );
endinterface

// File: rtl/rob_commit_ctrl.sv
// rob_commit_ctrl: reorder buffer that tags decoded instructions, collects CDB results and commits in order.
module rob_commit_ctrl #(
    parameter int ROB_SIZE = 16,
    parameter int ROB_IDX  = 4,
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5
) (
    input logic in_clk,
    input logic in_rst,
    input logic in_rdy,
    rob_commit_ctrl_if.slave bus
);
    localparam int CW = ROB_IDX + 1;

    logic [ROB_IDX-1:0]  head, tail;
    logic [CW-1:0]       count;
    logic [ROB_SIZE-1:0] busy, done, is_br, mis;
    logic [REG_W-1:0]    rd_q  [ROB_SIZE];
    logic [DATA_W-1:0]   val_q [ROB_SIZE];
    logic [DATA_W-1:0]   tgt_q [ROB_SIZE];
    logic                full, do_alloc, do_wb, do_commit, do_flush, byp_a, byp_b;
    logic                commit_en, flush_en;
    logic [REG_W-1:0]    c_rd;
    logic [DATA_W-1:0]   c_val, f_pc;
    logic [ROB_IDX-1:0]  c_tag;

    assign full      = count == CW'(ROB_SIZE);
    assign do_alloc  = bus.in_decoder_alloc_enable && !full;
    assign do_wb     = bus.in_cdb_enable && busy[bus.in_cdb_tag];
    assign do_commit = count != '0 && done[head];
    assign do_flush  = do_commit && is_br[head] && mis[head];

    // A result on the CDB this cycle is forwarded straight to the operand lookups.
    assign byp_a = bus.in_cdb_enable && bus.in_cdb_tag == bus.in_query_tag_a;
    assign byp_b = bus.in_cdb_enable && bus.in_cdb_tag == bus.in_query_tag_b;

    assign bus.out_decoder_full      = full;
    assign bus.out_decoder_alloc_tag = tail;
    assign bus.out_query_ready_a     = byp_a || (busy[bus.in_query_tag_a] && done[bus.in_query_tag_a]);
    assign bus.out_query_ready_b     = byp_b || (busy[bus.in_query_tag_b] && done[bus.in_query_tag_b]);
    assign bus.out_query_value_a     = byp_a ? bus.in_cdb_value : val_q[bus.in_query_tag_a];
    assign bus.out_query_value_b     = byp_b ? bus.in_cdb_value : val_q[bus.in_query_tag_b];
    assign bus.out_reg_commit_enable = commit_en;
    assign bus.out_reg_rd_addr       = c_rd;
    assign bus.out_reg_rd_value      = c_val;
    assign bus.out_reg_reorder       = c_tag;
    assign bus.out_flush_enable      = flush_en;
    assign bus.out_flush_pc          = f_pc;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            busy      <= '0;
            done      <= '0;
            commit_en <= 1'b0;
            flush_en  <= 1'b0;
            c_rd      <= '0;
            c_val     <= '0;
            c_tag     <= '0;
            f_pc      <= '0;
        end else if (!in_rdy) begin
            commit_en <= 1'b0;
            flush_en  <= 1'b0;
        end else begin
            commit_en <= do_commit;
            flush_en  <= do_flush;
            if (do_commit) begin
                c_rd  <= rd_q[head];
                c_val <= val_q[head];
                c_tag <= head;
            end
            // A mispredict squashes everything younger, including this cycle's alloc/writeback.
            if (do_flush) begin
                f_pc  <= tgt_q[head];
                head  <= '0;
                tail  <= '0;
                count <= '0;
                busy  <= '0;
                done  <= '0;
            end else begin
                if (do_wb) begin
                    done[bus.in_cdb_tag]  <= 1'b1;
                    val_q[bus.in_cdb_tag] <= bus.in_cdb_value;
                    mis[bus.in_cdb_tag]   <= bus.in_cdb_mispredict;
                    tgt_q[bus.in_cdb_tag] <= bus.in_cdb_target_pc;
                end
                if (do_commit) begin
                    busy[head] <= 1'b0;
                    done[head] <= 1'b0;
                    head       <= head + ROB_IDX'(1);
                end
                if (do_alloc) begin
                    busy[tail]  <= 1'b1;
                    done[tail]  <= 1'b0;
                    rd_q[tail]  <= bus.in_decoder_rd;
                    is_br[tail] <= bus.in_decoder_is_branch;
                    mis[tail]   <= 1'b0;
                    tail        <= tail + ROB_IDX'(1);
                end
                count <= count + CW'(do_alloc) - CW'(do_commit);
            end
        end
    end
endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- Reorder-buffer controller that allocates reorder tags to decoded instructions and collects results from the CDB.
- Commits results strictly in program order into the register file (drives its commit and flush inputs).
- Signals pipeline flush on a mispredicted branch or jalr.
- Sits between decoder, CDB and register file; in_rdy stalls the whole block.

Parameters:
- ROB_SIZE, 16, number of entries (power of two)
- ROB_IDX, 4, log2(ROB_SIZE); tag width
- DATA_W, 32, data/PC width
- REG_W, 5, architectural register index width

Ports:
- in_clk  input  1  clock
- in_rst  input  1  synchronous active-high reset
- in_rdy  input  1  global enable; low = hold all state
- in_decoder_alloc_enable  input  1  allocate one entry this cycle
- in_decoder_rd  input  REG_W  destination register of allocated instruction
- in_decoder_is_branch  input  1  entry may redirect PC (branch/jalr)
- out_decoder_full  output  1  count == ROB_SIZE (combinational)
- out_decoder_alloc_tag  output  ROB_IDX  tag the next allocation receives (= tail)
- in_cdb_enable  input  1  result valid
- in_cdb_tag  input  ROB_IDX  entry being completed
- in_cdb_value  input  DATA_W  result (rd value)
- in_cdb_mispredict  input  1  branch resolved wrong
- in_cdb_target_pc  input  DATA_W  correct PC when mispredicted
- in_query_tag_a / in_query_tag_b  input  ROB_IDX  operand lookup tags
- out_query_ready_a / out_query_ready_b  output  1  result available (combinational)
- out_query_value_a / out_query_value_b  output  DATA_W  result value
- out_reg_commit_enable  output  1  registered one-cycle commit pulse
- out_reg_rd_addr  output  REG_W  committed rd
- out_reg_rd_value  output  DATA_W  committed value
- out_reg_reorder  output  ROB_IDX  committed tag
- out_flush_enable  output  1  registered one-cycle flush pulse
- out_flush_pc  output  DATA_W  redirect PC

Behaviour:
- State: head, tail (ROB_IDX bits, wrap mod ROB_SIZE), count (ROB_IDX+1 bits). Per entry: busy, ready, rd, is_branch, mispredict, value, target.
- Reset (in_rst at posedge, overrides in_rdy): head = tail = count = 0, all busy/ready = 0, all registered outputs = 0.
- in_rdy = 0: no state change. out_reg_commit_enable and out_flush_enable are driven 0 at that edge; the other registered outputs hold.
- Allocation: in_decoder_alloc_enable && !full at an edge writes entry[tail] = {busy 1, ready 0, rd, is_branch, mispredict 0}, then tail++.
  - Allocation while full is ignored.
  - The decoder writes out_decoder_alloc_tag into the register file in the same cycle.
- Writeback: in_cdb_enable && busy[in_cdb_tag] sets ready, value, mispredict, target. A writeback to a non-busy entry is ignored.
- Commit: at each edge, if count > 0 && ready[head]:
  - register out_reg_commit_enable = 1, rd_addr = rd[head], rd_value = value[head], reorder = head;
  - clear busy[head]; head++.
  - Otherwise commit_enable = 0.
  - At most one commit per cycle. rd = 0 still pulses; the register file discards x0.
- Latency: a CDB writeback sampled at edge k to the head entry produces the commit pulse visible after edge k+1.
- Flush: if the committing entry has is_branch && mispredict:
  - register out_flush_enable = 1 and out_flush_pc = target in the same cycle as its commit pulse (the register file writes jalr rd during flush);
  - at that same edge, clear all entries and set head = tail = count = 0;
  - any allocation or writeback in that cycle is discarded.
  - The next cycle shows full = 0 and alloc_tag = 0.
- Simultaneous allocate and commit: count unchanged, head and tail both advance.
- A writeback to the head entry in the same cycle as the head check is not committed that cycle; it commits next cycle.
- Query (combinational):
  - ready = busy[tag] && ready[tag], value = value[tag];
  - bypass: if in_cdb_enable && in_cdb_tag == tag, ready = 1 and value = in_cdb_value.
- Full: count == ROB_SIZE; tail == head is disambiguated by count.

Test Plan:
- Reset, then alloc rd=5 (tag 0) and rd=6 (tag 1); CDB tag 1 value 0x22 then tag 0 value 0x11 -> commit pulses in order: (5, 0x11, tag 0), then (6, 0x22, tag 1).
- Allocate 16 entries with no commits -> out_decoder_full = 1. A 17th alloc is ignored (tail stays 0). Completing tag 0 then allocating rd=7 -> the new entry gets tag 0 (wrap).
- Branch tag 2 mispredict, target 0x1000, with tags 3-4 pending -> flush pulse with pc 0x1000 coincides with the tag 2 commit; next cycle alloc_tag = 0, count = 0, tags 3-4 never commit.
- in_rdy low for 3 cycles while head is ready -> no commit pulse and no state change; the commit occurs on the first edge with in_rdy high.
- Query tag 3 while CDB writes tag 3 value 0xABCD in the same cycle -> ready_a = 1, value_a = 0xABCD. Query a non-ready tag -> ready_a = 0.
- Assert in_rst mid-stream with 5 entries busy -> all outputs 0, alloc_tag = 0, and subsequent CDB writes to old tags are ignored.
